// File: rtl/bkram_sd_sequencer.sv
// Backup-RAM save/load sequencer: walks one slot's sectors through the hps_io
// sd_rd/sd_wr handshake, tracks dirty state, autosaves on request, aborts on timeout.
module bkram_sd_sequencer #(
  parameter  int SECTORS = 64,
  parameter  int SLOTS   = 4,
  parameter  int LBA_W   = 32,
  parameter  int TIMEOUT = 2**24,
  localparam int SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int IW      = $clog2(SECTORS),
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             autosave_trig,
  input  logic [SW-1:0]    slot,
  input  logic             bram_wr,
  input  logic             sd_ack,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             busy,
  output logic             loading,
  output logic             dirty,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t        r_state;
  logic [SW-1:0] r_slot;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_load;
  logic          r_ack, r_old_ack;
  logic          r_old_load, r_old_save;

  logic w_ld, w_sv, w_ld_edge, w_sv_edge, w_auto, w_start, w_rise, w_fall;

  assign w_ld      = load_req & ena;
  assign w_sv      = save_req & ena;
  assign w_ld_edge = w_ld & ~r_old_load;
  assign w_sv_edge = w_sv & ~r_old_save;
  assign w_auto    = autosave_trig & dirty & ena;
  assign w_start   = w_ld_edge | w_sv_edge | w_auto;
  // sd_ack is registered once before edge detection, so reactions land two cycles late
  assign w_rise    = r_ack & ~r_old_ack;
  assign w_fall    = ~r_ack & r_old_ack;

  assign sd_lba = LBA_W'({r_slot, r_idx});

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_slot     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_load     <= 1'b0;
      r_ack      <= 1'b0;
      r_old_ack  <= 1'b0;
      r_old_load <= 1'b0;
      r_old_save <= 1'b0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      busy       <= 1'b0;
      loading    <= 1'b0;
      dirty      <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      r_ack      <= sd_ack;
      r_old_ack  <= r_ack;
      r_old_load <= w_ld;
      r_old_save <= w_sv;
      done       <= 1'b0;
      error      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_slot  <= (SLOTS > 1) ? slot : '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_load  <= w_ld_edge;
            busy    <= 1'b1;
            loading <= w_ld_edge;
            sd_rd   <= w_ld_edge;
            sd_wr   <= ~w_ld_edge;
            if (!w_ld_edge) dirty <= 1'b0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_rise) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            r_state <= XFER;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            error   <= 1'b1;
            busy    <= 1'b0;
            loading <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        XFER: begin
          if (w_fall) begin
            if (!ena) begin
              error   <= 1'b1;
              busy    <= 1'b0;
              loading <= 1'b0;
              r_state <= IDLE;
            end else if (r_idx == IW'(SECTORS - 1)) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              loading <= 1'b0;
              if (r_load) dirty <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_cnt   <= '0;
              sd_rd   <= r_load;
              sd_wr   <= ~r_load;
              r_state <= REQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // a core write always wins over any clear in the same cycle
      if (bram_wr) dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bkram_sd_sequencer.sv
// Directed bench for bkram_sd_sequencer: acks each sector strobe and checks
// LBA sequence, dirty tracking, start priority, timeout, ena abort and reset.
module tb_bkram_sd_sequencer;
  localparam int SECTORS = 64;
  localparam int SLOTS   = 4;
  localparam int LBA_W   = 32;
  localparam int TIMEOUT = 16;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             ena = 1'b1, load_req = 1'b0, save_req = 1'b0, autosave_trig = 1'b0;
  logic [1:0]       slot = '0;
  logic             bram_wr = 1'b0, sd_ack = 1'b0;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd, sd_wr, busy, loading, dirty, done, error;

  int n_assert = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  logic p_rd = 1'b0, p_wr = 1'b0;

  bkram_sd_sequencer #(.SECTORS(SECTORS), .SLOTS(SLOTS), .LBA_W(LBA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ena(ena), .load_req(load_req), .save_req(save_req),
    .autosave_trig(autosave_trig), .slot(slot), .bram_wr(bram_wr), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .busy(busy), .loading(loading),
    .dirty(dirty), .done(done), .error(error)
  );

  always #5 clk_sys = ~clk_sys;

  // strobe rising-edge counters
  always @(negedge clk_sys) begin
    if (sd_rd && !p_rd) rd_cnt++;
    if (sd_wr && !p_wr) wr_cnt++;
    p_rd = sd_rd;
    p_wr = sd_wr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_strobe(input bit is_rd, input int lba, input bit exp_load, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) begin seen = 1'b1; break; end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_lba"}, 64'(sd_lba), 64'(lba));
    chk({tag, "_rdwr"}, {62'd0, sd_rd, sd_wr}, {62'd0, is_rd, !is_rd});
    chk({tag, "_busyld"}, {62'd0, busy, loading}, {62'd0, 1'b1, exp_load});
  endtask

  task automatic ack_hi(input string tag);
    bit low = 1'b0;
    sd_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (!sd_rd && !sd_wr) begin low = 1'b1; break; end
    end
    chk({tag, "_strobe_drop"}, 64'(low), 64'd1);
  endtask

  task automatic serve(input bit is_rd, input int lba, input bit exp_load, input string tag);
    wait_strobe(is_rd, lba, exp_load, tag);
    ack_hi(tag);
    sd_ack = 1'b0;
  endtask

  task automatic wait_end(input bit exp_err, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      if (done || error) begin seen = 1'b1; break; end
    end
    chk({tag, "_end_seen"}, 64'(seen), 64'd1);
    chk({tag, "_done_err"}, {62'd0, done, error}, {62'd0, !exp_err, exp_err});
    chk({tag, "_idle"}, {62'd0, busy, loading}, 64'd0);
    @(negedge clk_sys);
    chk({tag, "_one_cycle"}, {62'd0, done, error}, 64'd0);
  endtask

  initial begin
    int base, n;
    // reset state
    idle(2);
    chk("reset_outs", {sd_lba, sd_rd, sd_wr, busy, loading, dirty, done, error}, 64'd0);
    reset_n = 1'b1;
    idle(2);

    // load of slot 2: dirty set beforehand must be cleared by the completed load
    bram_wr = 1'b1; @(negedge clk_sys); bram_wr = 1'b0;
    chk("pre_load_dirty", 64'(dirty), 64'd1);
    base = wr_cnt;
    slot = 2'd2; load_req = 1'b1;
    for (int i = 0; i < SECTORS; i++) serve(1'b1, 128 + i, 1'b1, "load_s2");
    wait_end(1'b0, "load_s2");
    load_req = 1'b0;
    chk("load_dirty_after", 64'(dirty), 64'd0);
    chk("load_no_wr", 64'(wr_cnt - base), 64'd0);

    // autosave slot 0 after a write
    bram_wr = 1'b1; @(negedge clk_sys); bram_wr = 1'b0;
    chk("auto_dirty_before", 64'(dirty), 64'd1);
    base = wr_cnt;
    slot = 2'd0; autosave_trig = 1'b1; @(negedge clk_sys); autosave_trig = 1'b0;
    chk("auto_start_clears", {62'd0, busy, dirty}, {62'd0, 1'b1, 1'b0});
    for (int i = 0; i < SECTORS; i++) serve(1'b0, i, 1'b0, "auto_s0");
    wait_end(1'b0, "auto_s0");
    chk("auto_wr_count", 64'(wr_cnt - base), 64'(SECTORS));
    chk("auto_dirty_after", 64'(dirty), 64'd0);
    base = wr_cnt;
    autosave_trig = 1'b1; @(negedge clk_sys); autosave_trig = 1'b0;
    idle(5);
    chk("auto_clean_busy", 64'(busy), 64'd0);
    chk("auto_clean_nowr", 64'(wr_cnt - base), 64'd0);

    // simultaneous load and save edges: load wins, save is dropped
    base = wr_cnt;
    slot = 2'd3; load_req = 1'b1; save_req = 1'b1;
    for (int i = 0; i < SECTORS; i++) serve(1'b1, 192 + i, 1'b1, "both_s3");
    wait_end(1'b0, "both_s3");
    idle(5);
    chk("both_save_lost", 64'(wr_cnt - base), 64'd0);
    chk("both_busy", 64'(busy), 64'd0);
    load_req = 1'b0; save_req = 1'b0;
    idle(2);

    // timeout: never ack
    slot = 2'd1; load_req = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (sd_rd) n++;
      else if (n > 0) break;
    end
    chk("to_strobe_cycles", 64'(n), 64'(TIMEOUT));
    chk("to_error", 64'(error), 64'd1);
    chk("to_idle", {62'd0, busy, loading}, 64'd0);
    @(negedge clk_sys);
    chk("to_err_one_cycle", 64'(error), 64'd0);
    load_req = 1'b0;
    idle(2);

    // ena dropped during sector 5 of a save
    base = wr_cnt;
    slot = 2'd0; save_req = 1'b1;
    for (int i = 0; i < 5; i++) serve(1'b0, i, 1'b0, "ena_save");
    save_req = 1'b0;
    wait_strobe(1'b0, 5, 1'b0, "ena_s5");
    ack_hi("ena_s5");
    ena = 1'b0; sd_ack = 1'b0;
    wait_end(1'b1, "ena_abort");
    idle(10);
    chk("ena_wr_count", 64'(wr_cnt - base), 64'd6);
    ena = 1'b1;
    idle(2);

    // bram_wr during a save keeps dirty set
    slot = 2'd1; save_req = 1'b1;
    for (int i = 0; i < SECTORS; i++) begin
      serve(1'b0, 64 + i, 1'b0, "save_s1");
      if (i == 20) begin bram_wr = 1'b1; @(negedge clk_sys); bram_wr = 1'b0; end
    end
    wait_end(1'b0, "save_s1");
    save_req = 1'b0;
    chk("save_dirty_kept", 64'(dirty), 64'd1);

    // reset at sector 10 of a load, then a fresh save starts at index 0
    slot = 2'd2; load_req = 1'b1;
    for (int i = 0; i < 10; i++) serve(1'b1, 128 + i, 1'b1, "rst_load");
    wait_strobe(1'b1, 138, 1'b1, "rst_s10");
    reset_n = 1'b0;
    #1;
    chk("rst_async_outs", {sd_lba, sd_rd, sd_wr, busy, loading, dirty, done, error}, 64'd0);
    load_req = 1'b0;
    @(negedge clk_sys); reset_n = 1'b1;
    idle(2);
    chk("rst_no_pulse", {62'd0, done, error}, 64'd0);
    slot = 2'd3; save_req = 1'b1;
    for (int i = 0; i < SECTORS; i++) serve(1'b0, 192 + i, 1'b0, "post_rst_save");
    wait_end(1'b0, "post_rst_save");
    save_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
